// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP, on open-drain SCL/SDA.
// Build option I2C_MASTER_READ_EN enables the read path; without it every transfer is a write.
module i2c_master_byte #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       SCL,
    inout  logic       SDA
);

    typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rw_q, rw_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic        scl_low_q, scl_low_d;
    logic        sda_low_q, sda_low_d;
    logic        sda_s1_q, sda_s2_q;
    logic        rw_eff, qtr_end, bit_end, sample;

`ifdef I2C_MASTER_READ_EN
    assign rw_eff = rw;
`else
    logic rw_unused;
    assign rw_unused = rw;
    assign rw_eff    = 1'b0;
`endif

    assign qtr_end = (div_q == DIV_LAST);
    assign bit_end = qtr_end && (qtr_q == 2'd3);
    assign sample  = qtr_end && (qtr_q == 2'd2);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        wdat_d    = wdat_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;

        if (state_q == IDLE) begin
            div_d = '0;
            qtr_d = '0;
            bit_d = '0;
            if (start) begin
                state_d   = START;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                rw_d      = rw_eff;
                tx_d      = {addr, rw_eff};
                wdat_d    = wr_data;
            end
        end else begin
            div_d = qtr_end ? '0 : div_q + 16'd1;
            if (qtr_end) begin
                qtr_d = qtr_q + 2'd1;
            end
            if (sample) begin
                if ((state_q == ACK1 || (state_q == ACK2 && !rw_q)) && sda_s2_q) begin
                    ack_err_d = 1'b1;
                end
                if (state_q == DATA) begin
                    rx_d = {rx_q[6:0], sda_s2_q};
                end
            end
            if (bit_end) begin
                case (state_q)
                    START: begin
                        state_d = ADDR;
                        bit_d   = 3'd7;
                    end
                    ADDR, DATA: begin
                        if (bit_q == 3'd0) begin
                            state_d = (state_q == ADDR) ? ACK1 : ACK2;
                        end else begin
                            bit_d = bit_q - 3'd1;
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                    // ack_err was already updated at the q2 sample of this bit
                    ACK1: begin
                        if (ack_err_q) begin
                            state_d = STOP;
                        end else begin
                            state_d = DATA;
                            bit_d   = 3'd7;
                            tx_d    = wdat_q;
                        end
                    end
                    ACK2: begin
                        state_d = STOP;
                        if (rw_q) begin
                            rd_data_d = rx_q;
                        end
                    end
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Bus levels follow the state/quarter being entered, so SDA only moves at q0 entry.
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        case (state_d)
            START: begin
                sda_low_d = qtr_d[1];
                scl_low_d = (qtr_d == 2'd3);
            end
            ADDR: begin
                scl_low_d = !qtr_d[1];
                sda_low_d = !tx_d[7];
            end
            DATA: begin
                scl_low_d = !qtr_d[1];
                sda_low_d = !rw_d && !tx_d[7];
            end
            ACK1, ACK2: scl_low_d = !qtr_d[1];
            STOP: begin
                scl_low_d = (qtr_d == 2'd0);
                sda_low_d = !qtr_d[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            wdat_q    <= '0;
            rx_q      <= '0;
            rd_data_q <= 8'hFF;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            wdat_q    <= wdat_d;
            rx_q      <= rx_d;
            rd_data_q <= rd_data_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
            sda_s1_q  <= SDA;
            sda_s2_q  <= sda_s1_q;
        end
    end

    assign SCL     = scl_low_q ? 1'b0 : 1'bz;
    assign SDA     = sda_low_q ? 1'b0 : 1'bz;
    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with CLK_DIV=4 and a behavioural I2C slave at address 27h.
// Define I2C_MASTER_READ_EN to exercise the read transfer instead of the write-only fallback.
module tb_i2c_master_byte;

    localparam int unsigned CLK_DIV = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic       rw      = 1'b0;
    logic [6:0] addr    = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       busy, done, ack_err;
    wire        scl_w, sda_w;

    pullup (scl_w);
    pullup (sda_w);

    int checks   = 0;
    int failures = 0;

    i2c_master_byte #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .SCL     (scl_w),
        .SDA     (sda_w)
    );

    always #5 clk = ~clk;

    // Slave: samples the bus on falling clk; START/STOP need SCL high in two consecutive samples.
    logic       s_low   = 1'b0;
    logic       s_scl_p = 1'b1;
    logic       s_sda_p = 1'b1;
    logic       s_rd    = 1'b0;
    logic [7:0] s_sh    = '0;
    logic [7:0] s_out   = '0;
    int         s_ph    = 0;
    int         s_nb    = 0;
    int         s_stops = 0;

    assign sda_w = (s_low && !reset) ? 1'b0 : 1'bz;

    always @(negedge clk) begin
        logic scl_n, sda_n;
        scl_n = scl_w;
        sda_n = sda_w;
        if (reset) begin
            s_ph    = 0;
            s_low   = 1'b0;
            s_scl_p = 1'b1;
            s_sda_p = 1'b1;
        end else begin
            if (s_scl_p && scl_n && s_sda_p && !sda_n) begin
                s_ph = 1;
                s_nb = 0;
                s_sh = '0;
            end else if (s_scl_p && scl_n && !s_sda_p && sda_n) begin
                s_ph  = 0;
                s_low = 1'b0;
                s_stops++;
            end else if (!s_scl_p && scl_n) begin
                if (s_ph == 1 || s_ph == 3) begin
                    s_sh = {s_sh[6:0], sda_n};
                    s_nb++;
                end else if (s_ph == 5) begin
                    s_nb++;
                end
            end else if (s_scl_p && !scl_n) begin
                case (s_ph)
                    1: if (s_nb == 8) begin
                        if (s_sh[7:1] == 7'h27) begin
                            s_low = 1'b1;
                            s_rd  = s_sh[0];
                            s_ph  = 2;
                        end else begin
                            s_ph = 0;
                        end
                    end
                    2: begin
                        s_nb = 0;
                        s_sh = '0;
                        if (s_rd) begin
                            s_low = !s_out[7];
                            s_ph  = 5;
                        end else begin
                            s_low = 1'b0;
                            s_ph  = 3;
                        end
                    end
                    3: if (s_nb == 8) begin
                        s_out = s_sh;
                        s_low = 1'b1;
                        s_ph  = 4;
                    end
                    4: begin
                        s_low = 1'b0;
                        s_ph  = 0;
                    end
                    5: if (s_nb < 8) begin
                        s_low = !s_out[7 - s_nb];
                    end else begin
                        s_low = 1'b0;
                        s_ph  = 0;
                    end
                    default: ;
                endcase
            end
            s_scl_p = scl_n;
            s_sda_p = sda_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one request for a fixed number of cycles after acceptance; done_at = -1 if done never rose.
    task automatic xfer(input logic r, input logic [6:0] a, input logic [7:0] d,
                        input int ign_at, input int probe_at, input int limit,
                        output int done_at, output int ndone, output logic busy1,
                        output logic busy_dn, output logic sda_probe);
        @(negedge clk);
        start   = 1'b1;
        rw      = r;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        start     = 1'b0;
        done_at   = -1;
        ndone     = 0;
        busy1     = 1'b0;
        busy_dn   = 1'b1;
        sda_probe = 1'b0;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) busy1 = busy;
            if (n == probe_at) sda_probe = sda_w;
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = n;
                    busy_dn = busy;
                end
            end
            start = (n == ign_at);
        end
        start = 1'b0;
    endtask

    initial begin
        int   done_at, ndone, stops0;
        logic busy1, busy_dn, sda_probe;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rd_data", rd_data, 8'hFF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_scl", scl_w, 1'b1);
        chk("rst_sda", sda_w, 1'b1);

        xfer(1'b0, 7'h27, 8'hA5, -1, -1, 400, done_at, ndone, busy1, busy_dn, sda_probe);
        chk("wr_done_at", done_at, 320);
        chk("wr_ack_err", ack_err, 1'b0);
        chk("wr_slave_out", s_out, 8'hA5);
        chk("wr_busy_after_accept", busy1, 1'b1);
        chk("wr_busy_in_done", busy_dn, 1'b0);

        stops0 = s_stops;
        xfer(1'b0, 7'h28, 8'h00, -1, -1, 300, done_at, ndone, busy1, busy_dn, sda_probe);
        chk("nack_done_at", done_at, 176);
        chk("nack_ack_err", ack_err, 1'b1);
        chk("nack_slave_out", s_out, 8'hA5);
        chk("nack_stop_seen", s_stops, stops0 + 1);

        xfer(1'b0, 7'h27, 8'h3C, 50, -1, 400, done_at, ndone, busy1, busy_dn, sda_probe);
        chk("ign_done_count", ndone, 1);
        chk("ign_done_at", done_at, 320);
        chk("ign_slave_out", s_out, 8'h3C);
        chk("ign_ack_err_cleared", ack_err, 1'b0);

`ifdef I2C_MASTER_READ_EN
        xfer(1'b1, 7'h27, 8'h00, -1, 295, 400, done_at, ndone, busy1, busy_dn, sda_probe);
        chk("rd_done_at", done_at, 320);
        chk("rd_data", rd_data, 8'h3C);
        chk("rd_ack_err", ack_err, 1'b0);
        chk("rd_ack2_sda_released", sda_probe, 1'b1);
`else
        xfer(1'b1, 7'h27, 8'h11, -1, -1, 400, done_at, ndone, busy1, busy_dn, sda_probe);
        chk("norw_done_at", done_at, 320);
        chk("norw_slave_out", s_out, 8'h11);
        chk("norw_rd_data", rd_data, 8'hFF);
        chk("norw_ack_err", ack_err, 1'b0);
`endif

        @(negedge clk);
        start   = 1'b1;
        rw      = 1'b0;
        addr    = 7'h27;
        wr_data = 8'h77;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n < 150; n++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("mid_scl_low", scl_w, 1'b0);
        chk("mid_slave_ack", sda_w, 1'b0);
        reset = 1'b1;
        #1;
        chk("abort_scl", scl_w, 1'b1);
        chk("abort_sda", sda_w, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        xfer(1'b0, 7'h27, 8'h5A, -1, -1, 400, done_at, ndone, busy1, busy_dn, sda_probe);
        chk("post_rst_done_at", done_at, 320);
        chk("post_rst_slave_out", s_out, 8'h5A);
        chk("post_rst_ack_err", ack_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
